// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the number of clk cycles between consecutive
// transitions (either polarity) of a slow signal sig_in, reports the latest
// half period and flags lock once enough consecutive results agree.
//
// Build option: define CLK_METER_SYNC_EN to insert a 2-flop synchronizer on
// sig_in (asynchronous input). Without it sig_in must be synchronous to clk.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   en           in   measurement enable; low forces IDLE
//   sig_in       in   signal being measured
//   half_period  out  [WIDTH] last measured edge-to-edge cycle count
//   meas_valid   out  one-cycle pulse when half_period updates
//   locked       out  level, LOCK_COUNT consecutive matching measurements
//   timeout      out  one-cycle pulse when no edge arrives within TIMEOUT
module clk_period_meter #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      TOL        = 0,
    parameter logic [WIDTH-1:0] TIMEOUT    = {{(WIDTH-1){1'b1}}, 1'b0}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned     MATCH_W   = 4;
    localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_COUNT);
    localparam logic [WIDTH:0]  TOL_W     = (WIDTH+1)'(TOL);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     half_period_q, half_period_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 meas_valid_q, meas_valid_d;
    logic                 locked_q, locked_d;
    logic                 timeout_q, timeout_d;
    logic                 s_prev_q, s_prev_d;
    logic                 s;
    logic                 edge_det;
    logic [WIDTH:0]       diff;
    logic                 is_match;

`ifdef CLK_METER_SYNC_EN
    // Two-stage synchronizer for an asynchronous sig_in
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = sig_in;
`endif

    assign edge_det = s ^ s_prev_q;

    // |cnt - half_period| one bit wider so the subtraction cannot overflow
    always_comb begin
        if (cnt_q >= half_period_q) begin
            diff = {1'b0, cnt_q} - {1'b0, half_period_q};
        end else begin
            diff = {1'b0, half_period_q} - {1'b0, cnt_q};
        end
    end

    // match_q == 0 means no earlier measurement to compare against
    assign is_match = (match_q != '0) && (diff <= TOL_W);

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        half_period_d = half_period_q;
        match_d       = match_q;
        locked_d      = locked_q;
        meas_valid_d  = 1'b0;
        timeout_d     = 1'b0;
        s_prev_d      = s;

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = CNT_ONE;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = CNT_ONE;
                    if (edge_det) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge coinciding with cnt == TIMEOUT is a valid measurement
                    if (edge_det) begin
                        half_period_d = cnt_q;
                        meas_valid_d  = 1'b1;
                        cnt_d         = CNT_ONE;
                        if (is_match) begin
                            match_d = (match_q == LOCK_MAX) ? LOCK_MAX : match_q + MATCH_W'(1);
                        end else begin
                            match_d = MATCH_W'(1);
                        end
                        locked_d = (match_d == LOCK_MAX);
                    end else if (cnt_q == TIMEOUT) begin
                        state_d   = IDLE;
                        cnt_d     = CNT_ONE;
                        match_d   = '0;
                        locked_d  = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ONE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ONE;
            half_period_q <= '0;
            match_q       <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
            s_prev_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            half_period_q <= half_period_d;
            match_q       <= match_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
            s_prev_q      <= s_prev_d;
        end
    end

    assign half_period = half_period_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: two instances (TOL=0 and TOL=1, TIMEOUT=20)
// share stimulus; a cycle-level behavioural model predicts every output.
module tb_clk_period_meter;

    localparam int unsigned W      = 16;
    localparam int          TO_N   = 20;
    localparam int          LOCK_N = 4;
`ifdef CLK_METER_SYNC_EN
    localparam bit SYNC    = 1'b1;
    localparam int EXP_LAT = 4;
`else
    localparam bit SYNC    = 1'b0;
    localparam int EXP_LAT = 2;
`endif

    logic         clk;
    logic         reset;
    logic         en;
    logic         sig_in;
    logic [W-1:0] hp_w [2];
    logic         mv_w [2];
    logic         lk_w [2];
    logic         to_w [2];

    clk_period_meter #(.WIDTH(W), .LOCK_COUNT(LOCK_N), .TOL(0), .TIMEOUT(16'd20)) dut0 (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .half_period(hp_w[0]), .meas_valid(mv_w[0]), .locked(lk_w[0]), .timeout(to_w[0])
    );

    clk_period_meter #(.WIDTH(W), .LOCK_COUNT(LOCK_N), .TOL(1), .TIMEOUT(16'd20)) dut1 (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .half_period(hp_w[1]), .meas_valid(mv_w[1]), .locked(lk_w[1]), .timeout(to_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] e_hp [2];
    logic         e_mv [2];
    logic         e_lk [2];
    logic         e_to [2];
    bit           ref_v [2];
    int           edge_cyc [2];
    int           hist [2][16];   // newest measurement at index 0
    int           nh [2];
    int           cyc;

    function automatic int tol_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // Length of the trailing run of measurements that agree pairwise within TOL
    function automatic int run_len(input int i);
        int r;
        int d;
        r = 1;
        for (int j = 0; j + 1 < nh[i] && r < LOCK_N; j++) begin
            d = hist[i][j] - hist[i][j+1];
            if (d < 0) d = -d;
            if (d <= tol_of(i)) r++;
            else break;
        end
        return r;
    endfunction

    initial begin : model
        bit s;
        bit prev_s;
        bit dl0;
        bit dl1;
        bit edge_seen;
        int m;
        cyc = 0;
        prev_s = 1'b0;
        dl0 = 1'b0;
        dl1 = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                dl0 = 1'b0; dl1 = 1'b0; prev_s = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    ref_v[i] = 1'b0; nh[i] = 0; e_hp[i] = '0;
                    e_mv[i] = 1'b0; e_lk[i] = 1'b0; e_to[i] = 1'b0;
                end
            end else begin
                // Value seen by the edge detector: sig_in, delayed 2 cycles if synchronized
                if (SYNC) begin
                    s = dl1; dl1 = dl0; dl0 = sig_in;
                end else begin
                    s = sig_in;
                end
                edge_seen = (s != prev_s);
                prev_s = s;
                for (int i = 0; i < 2; i++) begin
                    e_mv[i] = 1'b0;
                    e_to[i] = 1'b0;
                    if (!en) begin
                        ref_v[i] = 1'b0; nh[i] = 0; e_lk[i] = 1'b0;
                    end else if (edge_seen) begin
                        if (ref_v[i]) begin
                            m = cyc - edge_cyc[i];
                            e_hp[i] = W'(m);
                            e_mv[i] = 1'b1;
                            for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
                            hist[i][0] = m;
                            if (nh[i] < 16) nh[i]++;
                            e_lk[i] = (run_len(i) >= LOCK_N);
                        end
                        ref_v[i] = 1'b1;
                        edge_cyc[i] = cyc;
                    end else if (ref_v[i] && (cyc - edge_cyc[i] == TO_N)) begin
                        e_to[i] = 1'b1; ref_v[i] = 1'b0; nh[i] = 0; e_lk[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + event monitor ----------------
    int ncyc = 0;
    int last_mv_neg = 0;
    int to_neg = 0;
    int to_cnt = 0;
    int mv_cnt = 0;

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dut%0d_half_period", i), 32'(hp_w[i]), 32'(e_hp[i]));
                check($sformatf("dut%0d_meas_valid", i), 32'(mv_w[i]), 32'(e_mv[i]));
                check($sformatf("dut%0d_locked", i), 32'(lk_w[i]), 32'(e_lk[i]));
                check($sformatf("dut%0d_timeout", i), 32'(to_w[i]), 32'(e_to[i]));
            end
            if (mv_w[0] === 1'b1) begin last_mv_neg = ncyc; mv_cnt++; end
            if (to_w[0] === 1'b1) begin to_neg = ncyc; to_cnt++; end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle_gap(input int gap);
        sig_in = ~sig_in;
        wait_cyc(gap);
    endtask

    initial begin : driver
        int lat;
        reset = 1'b1; en = 1'b0; sig_in = 1'b0;
        wait_cyc(3);
        check("reset_half_period", 32'(hp_w[0]), 32'd0);
        check("reset_meas_valid", 32'(mv_w[0]), 32'd0);
        check("reset_locked", 32'(lk_w[0]), 32'd0);
        check("reset_timeout", 32'(to_w[0]), 32'd0);
        reset = 1'b0; en = 1'b1;
        wait_cyc(2);

        // Steady 5-cycle toggling: reference + 8 measurements
        for (int k = 0; k < 9; k++) toggle_gap(5);
        check("steady_half_period", 32'(hp_w[0]), 32'd5);
        check("steady_locked", 32'(lk_w[0]), 32'd1);

        // Stall after lock
        to_cnt = 0;
        wait_cyc(30);
        check("stall_timeout_count", 32'(to_cnt), 32'd1);
        check("stall_gap", 32'(to_neg - last_mv_neg), 32'd20);
        check("stall_locked", 32'(lk_w[0]), 32'd0);
        check("stall_half_period", 32'(hp_w[0]), 32'd5);

        // Jitter 5,5,6,5 then steady 5s
        toggle_gap(5); toggle_gap(5); toggle_gap(6); toggle_gap(5); toggle_gap(5);
        check("jitter_tol1_locked", 32'(lk_w[1]), 32'd1);
        check("jitter_tol0_unlocked", 32'(lk_w[0]), 32'd0);
        toggle_gap(5); toggle_gap(5);
        check("jitter_tol0_still_unlocked", 32'(lk_w[0]), 32'd0);
        toggle_gap(5);
        check("jitter_tol0_locked", 32'(lk_w[0]), 32'd1);
        wait_cyc(25);

        // Edge exactly at cnt == TIMEOUT
        to_cnt = 0;
        toggle_gap(20);
        toggle_gap(6);
        check("boundary_half_period", 32'(hp_w[0]), 32'd20);
        check("boundary_no_timeout", 32'(to_cnt), 32'd0);
        wait_cyc(25);
        check("boundary_later_timeout", 32'(to_cnt), 32'd1);

        // Reset mid-count while locked
        for (int k = 0; k < 6; k++) toggle_gap(5);
        check("pre_reset_locked", 32'(lk_w[0]), 32'd1);
        toggle_gap(2);
        reset = 1'b1; sig_in = 1'b0;
        wait_cyc(1);
        reset = 1'b0;
        check("midreset_half_period", 32'(hp_w[0]), 32'd0);
        check("midreset_locked", 32'(lk_w[0]), 32'd0);
        wait_cyc(3);
        mv_cnt = 0;
        toggle_gap(5);
        check("postreset_first_edge_no_meas", 32'(mv_cnt), 32'd0);
        toggle_gap(5);
        check("postreset_second_edge_meas", 32'(mv_cnt), 32'd1);
        check("postreset_half_period", 32'(hp_w[0]), 32'd5);

        // en dropped mid-count while locked
        for (int k = 0; k < 3; k++) toggle_gap(5);
        check("pre_en_locked", 32'(lk_w[0]), 32'd1);
        toggle_gap(2);
        en = 1'b0;
        wait_cyc(3);
        check("en_low_locked", 32'(lk_w[0]), 32'd0);
        check("en_low_half_period_held", 32'(hp_w[0]), 32'd5);
        en = 1'b1;
        wait_cyc(2);
        mv_cnt = 0;
        toggle_gap(5);
        check("en_restart_first_edge_no_meas", 32'(mv_cnt), 32'd0);
        toggle_gap(6);
        check("en_restart_second_edge_meas", 32'(mv_cnt), 32'd1);

        // Latency: sig_in toggle to the clock edge at which meas_valid is captured
        sig_in = ~sig_in;
        lat = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (mv_w[0] === 1'b1) begin
                lat = j + 1;
                break;
            end
        end
        check("latency", 32'(lat), 32'(EXP_LAT));
        check("latency_half_period", 32'(hp_w[0]), 32'd6);
        wait_cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
